// File: rtl/dc2_tile_arbiter.sv
// Two-port round-robin arbiter in front of the L2 data-cache tile.
// One tile transaction at a time; hung accesses time out with FAULT.
//
// Ports:
//   clock, reset        : clock, async active-low reset
//   a*/b*In{Addr,Data,OE,WR,Op} : requester A (ifetch) / B (ld/st)
//   a*/b*Out{Data,OK}   : latched response per requester
//   tile{Addr,OutData,OE,WR,Op} : request to the tile
//   tile{InData,OK}     : response from the tile
//   grant               : debug, 01 A, 10 B, 00 none
module dc2_tile_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  aInAddr,
  input  logic [127:0] aInData,
  input  logic         aInOE,
  input  logic         aInWR,
  input  logic [4:0]   aInOp,
  input  logic [31:0]  bInAddr,
  input  logic [127:0] bInData,
  input  logic         bInOE,
  input  logic         bInWR,
  input  logic [4:0]   bInOp,
  output logic [127:0] aOutData,
  output logic [1:0]   aOutOK,
  output logic [127:0] bOutData,
  output logic [1:0]   bOutOK,
  output logic [31:0]  tileAddr,
  output logic [127:0] tileOutData,
  output logic         tileOE,
  output logic         tileWR,
  output logic [4:0]   tileOp,
  input  logic [127:0] tileInData,
  input  logic [1:0]   tileOK,
  output logic [1:0]   grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;
  localparam logic [1:0] G_NONE   = 2'b00;
  localparam logic [1:0] G_A      = 2'b01;
  localparam logic [1:0] G_B      = 2'b10;
  localparam logic [7:0] TMO      = 8'(TIMEOUT_CYCLES);

  state_t         r_state;
  state_t         w_state_nx;
  logic [1:0]     r_grant;
  logic [1:0]     w_grant_nx;
  logic           r_last_b;
  logic           w_last_b_nx;
  logic [7:0]     r_hold;
  logic [7:0]     w_hold_nx;
  logic [1:0]     r_rsp_ok;
  logic [1:0]     w_rsp_ok_nx;
  logic [127:0]   r_rsp_data;
  logic [127:0]   w_rsp_data_nx;

  logic           w_a_req;
  logic           w_b_req;
  logic           w_sel_b;
  logic           w_sel_req;
  logic           w_busy;
  logic           w_done;

  assign w_a_req   = aInOE | aInWR;
  assign w_b_req   = bInOE | bInWR;
  assign w_sel_b   = r_grant[1];
  assign w_sel_req = w_sel_b ? w_b_req : w_a_req;
  assign w_busy    = (r_state == S_BUSY);
  assign w_done    = (r_state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= G_NONE;
      r_last_b   <= 1'b1;
      r_hold     <= 8'd0;
      r_rsp_ok   <= OK_READY;
      r_rsp_data <= 128'd0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_last_b   <= w_last_b_nx;
      r_hold     <= w_hold_nx;
      r_rsp_ok   <= w_rsp_ok_nx;
      r_rsp_data <= w_rsp_data_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_last_b_nx   = r_last_b;
    w_hold_nx     = r_hold;
    w_rsp_ok_nx   = r_rsp_ok;
    w_rsp_data_nx = r_rsp_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_a_req | w_b_req) begin
          w_state_nx = S_BUSY;
          w_hold_nx  = 8'd0;
          // on a tie, the port that did not go last wins
          if (w_a_req && (!w_b_req || r_last_b))
            w_grant_nx = G_A;
          else
            w_grant_nx = G_B;
        end
      end
      S_BUSY: begin
        if (!w_sel_req) begin
          // abort: requester gave up, no response
          w_state_nx  = S_IDLE;
          w_grant_nx  = G_NONE;
          w_last_b_nx = w_sel_b;
        end else if (tileOK == OK_OK ||
                     tileOK == OK_FAULT) begin
          w_state_nx    = S_DONE;
          w_rsp_ok_nx   = tileOK;
          w_rsp_data_nx = tileInData;
        end else if (r_hold == TMO) begin
          w_state_nx    = S_DONE;
          w_rsp_ok_nx   = OK_FAULT;
          w_rsp_data_nx = 128'd0;
        end else if (r_hold != 8'hFF) begin
          w_hold_nx = r_hold + 8'd1;
        end
      end
      S_DONE: begin
        if (!w_sel_req) begin
          w_state_nx    = S_IDLE;
          w_grant_nx    = G_NONE;
          w_last_b_nx   = w_sel_b;
          w_rsp_ok_nx   = OK_READY;
          w_rsp_data_nx = 128'd0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = G_NONE;
      end
    endcase
  end

  // tile sees the granted port only while BUSY
  always_comb begin
    tileAddr    = 32'd0;
    tileOutData = 128'd0;
    tileOE      = 1'b0;
    tileWR      = 1'b0;
    tileOp      = 5'd0;
    if (w_busy) begin
      if (w_sel_b) begin
        tileAddr    = bInAddr;
        tileOutData = bInData;
        tileOE      = bInOE & ~bInWR;
        tileWR      = bInWR;
        tileOp      = bInOp;
      end else begin
        tileAddr    = aInAddr;
        tileOutData = aInData;
        tileOE      = aInOE & ~aInWR;
        tileWR      = aInWR;
        tileOp      = aInOp;
      end
    end
  end

  // outputs forced quiet while reset is held, even if a port requests
  always_comb begin
    aOutOK   = OK_READY;
    aOutData = 128'd0;
    bOutOK   = OK_READY;
    bOutData = 128'd0;
    if (reset) begin
      if (w_done && r_grant == G_A) begin
        aOutOK   = r_rsp_ok;
        aOutData = r_rsp_data;
      end else if (w_a_req) begin
        aOutOK = OK_HOLD;
      end
      if (w_done && r_grant == G_B) begin
        bOutOK   = r_rsp_ok;
        bOutData = r_rsp_data;
      end else if (w_b_req) begin
        bOutOK = OK_HOLD;
      end
    end
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_dc2_tile_arbiter.sv
// Bench for dc2_tile_arbiter: tile RAM/ROM model, two requesters,
// response scoreboard per port.
module tb_dc2_tile_arbiter;

  localparam logic [1:0] READY = 2'd0;
  localparam logic [1:0] OK    = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  aInAddr = '0, bInAddr = '0;
  logic [127:0] aInData = '0, bInData = '0;
  logic         aInOE = 1'b0, bInOE = 1'b0;
  logic         aInWR = 1'b0, bInWR = 1'b0;
  logic [4:0]   aInOp = '0, bInOp = '0;
  logic [127:0] aOutData, bOutData;
  logic [1:0]   aOutOK, bOutOK;
  logic [31:0]  tileAddr;
  logic [127:0] tileOutData;
  logic         tileOE, tileWR;
  logic [4:0]   tileOp;
  logic [127:0] tileInData;
  logic [1:0]   tileOK;
  logic [1:0]   grant;

  dc2_tile_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clk), .reset(rst_n),
    .aInAddr(aInAddr), .aInData(aInData),
    .aInOE(aInOE), .aInWR(aInWR), .aInOp(aInOp),
    .bInAddr(bInAddr), .bInData(bInData),
    .bInOE(bInOE), .bInWR(bInWR), .bInOp(bInOp),
    .aOutData(aOutData), .aOutOK(aOutOK),
    .bOutData(bOutData), .bOutOK(bOutOK),
    .tileAddr(tileAddr), .tileOutData(tileOutData),
    .tileOE(tileOE), .tileWR(tileWR), .tileOp(tileOp),
    .tileInData(tileInData), .tileOK(tileOK),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // tile model: RAM needs one HOLD cycle, ROM/MMIO answers at once
  logic [127:0] mem [0:2047];
  logic         stuck = 1'b0;
  int           tcnt = 0;
  logic         t_act, t_ram;
  logic [127:0] t_line;

  initial for (int i = 0; i < 2048; i++) mem[i] = '0;

  always_comb begin
    t_act      = tileOE | tileWR;
    t_ram      = (tileAddr[31:15] == 17'h01800);
    t_line     = mem[tileAddr[14:4]];
    tileOK     = READY;
    tileInData = '0;
    if (t_act) begin
      if (t_ram)
        tileOK = (tcnt == 0) ? HOLD : OK;
      else
        tileOK = stuck ? HOLD : OK;
      if (!tileWR && tileOK == OK) begin
        if (!t_ram)
          tileInData = {96'd0, tileAddr};
        else if (tileOp[1:0] == 2'b10)
          tileInData = {96'd0,
            t_line[32*tileAddr[3:2] +: 32]};
        else if (tileOp[1:0] == 2'b11)
          tileInData = {64'd0,
            t_line[64*tileAddr[3] +: 64]};
        else
          tileInData = t_line;
      end
    end
  end

  always @(posedge clk) begin
    tcnt <= t_act ? tcnt + 1 : 0;
    if (t_act && tileWR && t_ram && tileOK == OK) begin
      if (tileOp[1:0] == 2'b10)
        mem[tileAddr[14:4]][32*tileAddr[3:2] +: 32]
          <= tileOutData[31:0];
      else if (tileOp[1:0] == 2'b11)
        mem[tileAddr[14:4]][64*tileAddr[3] +: 64]
          <= tileOutData[63:0];
      else
        mem[tileAddr[14:4]] <= tileOutData;
    end
  end

  // scoreboard
  typedef struct {
    logic [1:0]   ok;
    logic [127:0] d;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  int   cyc = 0;
  int   rcnt [2] = '{0, 0};
  int   rcyc [2] = '{0, 0};
  bit   pa = 0, pb = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    bit ra, rb;
    ra = (aOutOK == OK) || (aOutOK == FAULT);
    rb = (bOutOK == OK) || (bOutOK == FAULT);
    if (rst_n) begin
      if (ra && !pa) begin
        if (qA.size() == 0) begin
          chk("a-unexpected", {126'd0, aOutOK}, 128'(READY));
        end else begin
          e = qA.pop_front();
          chk("a-ok", {126'd0, aOutOK}, {126'd0, e.ok});
          chk("a-data", aOutData, e.d);
          chk("a-grant", {126'd0, grant}, 128'd1);
        end
        rcnt[0]++;
        rcyc[0] = cyc;
      end
      if (rb && !pb) begin
        if (qB.size() == 0) begin
          chk("b-unexpected", {126'd0, bOutOK}, 128'(READY));
        end else begin
          e = qB.pop_front();
          chk("b-ok", {126'd0, bOutOK}, {126'd0, e.ok});
          chk("b-data", bOutData, e.d);
          chk("b-grant", {126'd0, grant}, 128'd2);
        end
        rcnt[1]++;
        rcyc[1] = cyc;
      end
      pa = ra;
      pb = rb;
    end else begin
      pa = 0;
      pb = 0;
    end
  end

  task automatic drive(input int p, input logic oe,
                       input logic wr, input logic [4:0] op,
                       input logic [31:0] addr,
                       input logic [127:0] d);
    if (p == 0) begin
      aInOE = oe; aInWR = wr; aInOp = op;
      aInAddr = addr; aInData = d;
    end else begin
      bInOE = oe; bInWR = wr; bInOp = op;
      bInAddr = addr; bInData = d;
    end
  endtask

  // issue, wait for the response, check latency, drop
  task automatic xact(input int p, input logic wr,
                      input logic [4:0] op,
                      input logic [31:0] addr,
                      input logic [127:0] d,
                      input logic [1:0] eok,
                      input logic [127:0] edat,
                      input int elat);
    exp_t e;
    int c0, n0;
    bit got;
    @(posedge clk); #1;
    e.ok = eok;
    e.d  = edat;
    if (p == 0) qA.push_back(e);
    else qB.push_back(e);
    drive(p, ~wr, wr, op, addr, d);
    c0  = cyc;
    n0  = rcnt[p];
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rcnt[p] != n0) begin
        got = 1;
        break;
      end
    end
    if (!got)
      chk(p == 0 ? "a-no-response" : "b-no-response",
          128'(got), 128'd1);
    else
      chk(p == 0 ? "a-latency" : "b-latency",
          128'(rcyc[p] - c0), 128'(elat));
    drive(p, 1'b0, 1'b0, 5'd0, 32'd0, 128'd0);
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, "-aok"}, {126'd0, aOutOK}, 128'd0);
    chk({tag, "-bok"}, {126'd0, bOutOK}, 128'd0);
    chk({tag, "-adata"}, aOutData, 128'd0);
    chk({tag, "-bdata"}, bOutData, 128'd0);
    chk({tag, "-taddr"}, {96'd0, tileAddr}, 128'd0);
    chk({tag, "-tdata"}, tileOutData, 128'd0);
    chk({tag, "-toe"}, {127'd0, tileOE}, 128'd0);
    chk({tag, "-twr"}, {127'd0, tileWR}, 128'd0);
    chk({tag, "-top"}, {123'd0, tileOp}, 128'd0);
    chk({tag, "-grant"}, {126'd0, grant}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] RAM10  = 32'h0C00_0010;
  localparam logic [31:0] RAM100 = 32'h0C00_0100;
  localparam logic [31:0] RAM108 = 32'h0C00_0108;
  localparam logic [63:0] DW     = 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    int n0;
    // reset values
    repeat (2) @(posedge clk);
    #1;
    quiet_outputs("reset");
    rst_n = 1'b1;

    // tie right after reset: A, B, A, B
    fork
      begin
        xact(0, 0, 5'd2, RAM10, '0, OK, 128'd0, 3);
        xact(0, 0, 5'd2, RAM10, '0, OK, 128'd0, 8);
      end
      begin
        xact(1, 0, 5'd2, RAM10, '0, OK, 128'd0, 8);
        xact(1, 0, 5'd2, RAM10, '0, OK, 128'd0, 8);
      end
    join

    // A 32-bit store then load, with per-cycle status checks
    xact(0, 1, 5'd2, RAM10, 128'h1122_3344,
         OK, 128'd0, 3);
    fork
      xact(0, 0, 5'd2, RAM10, '0, OK,
           128'h1122_3344, 3);
      begin
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k < 3)
            chk("a-hold", {126'd0, aOutOK}, 128'(HOLD));
          chk("b-ready", {126'd0, bOutOK}, 128'(READY));
        end
      end
    join

    // B 64-bit store, A 128-bit load of the line
    xact(1, 1, 5'd3, RAM108, {64'd0, DW}, OK, 128'd0, 3);
    xact(0, 0, 5'd0, RAM100, '0, OK, {DW, 64'd0}, 3);

    // boot ROM answers in the same cycle
    xact(1, 0, 5'd2, 32'h0000_1000, '0, OK,
         128'h1000, 2);

    // MMIO stuck at HOLD: FAULT after the timeout
    stuck = 1'b1;
    xact(0, 0, 5'd2, 32'h0F00_0000, '0, FAULT,
         128'd0, 6);
    @(posedge clk); #1;
    chk("tmo-idle-grant", {126'd0, grant}, 128'd0);
    chk("tmo-idle-aok", {126'd0, aOutOK}, 128'(READY));
    stuck = 1'b0;

    // A aborts in its first BUSY cycle, B waiting
    n0 = rcnt[0];
    fork
      begin
        @(posedge clk); #1;
        drive(0, 1, 0, 5'd2, RAM10, '0);
        @(posedge clk); #1;
        chk("abort-busy-oe", {127'd0, tileOE}, 128'd1);
        chk("abort-busy-grant", {126'd0, grant}, 128'd1);
        drive(0, 0, 0, 5'd0, 32'd0, '0);
        @(posedge clk); #1;
        chk("abort-idle-oe", {127'd0, tileOE}, 128'd0);
        chk("abort-idle-grant", {126'd0, grant}, 128'd0);
        chk("abort-aok", {126'd0, aOutOK}, 128'(READY));
        @(posedge clk); #1;
        chk("abort-b-grant", {126'd0, grant}, 128'd2);
      end
      begin
        @(posedge clk);
        xact(1, 0, 5'd2, RAM10, '0, OK,
             128'h1122_3344, 4);
      end
    join
    chk("abort-no-a-rsp", 128'(rcnt[0]), 128'(n0));

    // async reset during B's BUSY
    @(posedge clk); #1;
    drive(1, 1, 0, 5'd2, RAM10, '0);
    @(posedge clk); #1;
    chk("rst-busy-oe", {127'd0, tileOE}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    quiet_outputs("rst-async");
    drive(1, 0, 0, 5'd0, 32'd0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      xact(0, 0, 5'd2, RAM10, '0, OK, 128'h1122_3344, 3);
      xact(1, 0, 5'd2, RAM10, '0, OK, 128'h1122_3344, 8);
    join

    repeat (3) @(posedge clk);
    chk("qA-empty", 128'(qA.size()), 128'd0);
    chk("qB-empty", 128'(qB.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
